// File: rtl/chess_clock_timer.sv
// Two-sided chess clock: centisecond countdown per side with BCD shadows driving seven-segment displays.
// Displays are registered from next-state digits, so they track the counter on the same edge.
module chess_clock_timer #(
    parameter int CLK_HZ  = 50000000,
    parameter int INIT_CS = 60000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        move_done,
    input  logic        pause,
    input  logic        new_game,
    output logic [41:0] white_clock,
    output logic [41:0] black_clock,
    output logic        winner,
    output logic        winnerEnable,
    output logic        side_to_move
);

    localparam int DIV = (CLK_HZ / 100 < 1) ? 1 : CLK_HZ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [19:0]   INIT = 20'(INIT_CS);
    localparam int IM = INIT_CS / 6000;
    localparam int IS = (INIT_CS / 100) % 60;
    localparam int IC = INIT_CS % 100;
    localparam logic [23:0] INIT_BCD = {4'(IM / 10), 4'(IM % 10), 4'(IS / 10),
                                        4'(IS % 10), 4'(IC / 10), 4'(IC % 10)};

    typedef enum logic [2:0] {IDLE, RUN_W, RUN_B, PAUSED, DONE} state_t;

    // Digits, low to high: hundredths, tenths, seconds, tens of seconds (0..5), minutes, tens of minutes.
    function automatic logic [23:0] bcd_dec(input logic [23:0] d);
        logic [23:0] r;
        logic        borrow;
        r      = d;
        borrow = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (borrow) begin
                if (r[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = (k == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] encode(input logic [23:0] d);
        return {seg7(d[23:20]), seg7(d[19:16]), seg7(d[15:12]),
                seg7(d[11:8]),  seg7(d[7:4]),   seg7(d[3:0])};
    endfunction

    state_t        state, state_n;
    logic          psd, psd_n;
    logic [PW-1:0] presc, presc_n;
    logic [19:0]   w_cs, w_cs_n, b_cs, b_cs_n;
    logic [23:0]   w_bcd, w_bcd_n, b_bcd, b_bcd_n;
    logic          win_n, we_n, stm_n;
    logic          running, tick, timeout;

    assign running = (state == RUN_W) || (state == RUN_B);
    assign tick    = running && (presc == PMAX);

    always_comb begin
        state_n = state;
        psd_n   = psd;
        presc_n = presc;
        w_cs_n  = w_cs;
        b_cs_n  = b_cs;
        w_bcd_n = w_bcd;
        b_bcd_n = b_bcd;
        win_n   = winner;
        we_n    = winnerEnable;
        stm_n   = side_to_move;
        timeout = 1'b0;
        if (new_game) begin
            state_n = IDLE;
            presc_n = '0;
            w_cs_n  = INIT;
            b_cs_n  = INIT;
            w_bcd_n = INIT_BCD;
            b_bcd_n = INIT_BCD;
            win_n   = 1'b0;
            we_n    = 1'b0;
            stm_n   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stm_n = 1'b0;
                    if (start) state_n = RUN_W;
                end
                RUN_W, RUN_B: begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    if (tick && state == RUN_W && w_cs != 20'd0) begin
                        w_cs_n  = w_cs - 20'd1;
                        w_bcd_n = bcd_dec(w_bcd);
                        timeout = (w_cs == 20'd1);
                    end
                    if (tick && state == RUN_B && b_cs != 20'd0) begin
                        b_cs_n  = b_cs - 20'd1;
                        b_bcd_n = bcd_dec(b_bcd);
                        timeout = (b_cs == 20'd1);
                    end
                    // Timeout outranks pause, and pause outranks move_done.
                    if (timeout) begin
                        state_n = DONE;
                        win_n   = (state == RUN_W);
                        we_n    = 1'b1;
                    end else if (pause) begin
                        state_n = PAUSED;
                        psd_n   = (state == RUN_B);
                        presc_n = '0;
                    end else if (move_done) begin
                        state_n = (state == RUN_W) ? RUN_B : RUN_W;
                        presc_n = '0;
                        stm_n   = (state == RUN_W);
                    end
                end
                PAUSED: begin
                    if (pause) state_n = psd ? RUN_B : RUN_W;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            psd          <= 1'b0;
            presc        <= '0;
            w_cs         <= INIT;
            b_cs         <= INIT;
            w_bcd        <= INIT_BCD;
            b_bcd        <= INIT_BCD;
            winner       <= 1'b0;
            winnerEnable <= 1'b0;
            side_to_move <= 1'b0;
            white_clock  <= encode(INIT_BCD);
            black_clock  <= encode(INIT_BCD);
        end else begin
            state        <= state_n;
            psd          <= psd_n;
            presc        <= presc_n;
            w_cs         <= w_cs_n;
            b_cs         <= b_cs_n;
            w_bcd        <= w_bcd_n;
            b_bcd        <= b_bcd_n;
            winner       <= win_n;
            winnerEnable <= we_n;
            side_to_move <= stm_n;
            white_clock  <= encode(w_bcd_n);
            black_clock  <= encode(b_bcd_n);
        end
    end

endmodule

// File: tb/tb_chess_clock_timer.sv
// Three chess clock instances (fast, two-centisecond, divided default time) share stimulus and a reference model.
module tb_chess_clock_timer;

    localparam int S_IDLE = 0, S_RW = 1, S_RB = 2, S_PAUSED = 3, S_DONE = 4;

    logic clock, reset, start, move_done, pause, new_game;
    logic [41:0] wclk [3];
    logic [41:0] bclk [3];
    logic win [3], we [3], stm [3];

    int m_init [3] = '{300, 2, 60000};
    int m_div  [3] = '{1, 1, 3};
    int mt_w [3], mt_b [3], m_st [3], m_ph [3];
    logic m_psd [3], m_win [3], m_we [3], m_stm [3];
    int n_checks, n_fail;

    chess_clock_timer #(.CLK_HZ(100), .INIT_CS(300)) u0 (
        .clock(clock), .reset(reset), .start(start), .move_done(move_done), .pause(pause),
        .new_game(new_game), .white_clock(wclk[0]), .black_clock(bclk[0]), .winner(win[0]),
        .winnerEnable(we[0]), .side_to_move(stm[0]));
    chess_clock_timer #(.CLK_HZ(100), .INIT_CS(2)) u1 (
        .clock(clock), .reset(reset), .start(start), .move_done(move_done), .pause(pause),
        .new_game(new_game), .white_clock(wclk[1]), .black_clock(bclk[1]), .winner(win[1]),
        .winnerEnable(we[1]), .side_to_move(stm[1]));
    chess_clock_timer #(.CLK_HZ(300), .INIT_CS(60000)) u2 (
        .clock(clock), .reset(reset), .start(start), .move_done(move_done), .pause(pause),
        .new_game(new_game), .white_clock(wclk[2]), .black_clock(bclk[2]), .winner(win[2]),
        .winnerEnable(we[2]), .side_to_move(stm[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] disp(input int cs);
        int mi, se, fr;
        mi = cs / 6000;
        se = (cs / 100) % 60;
        fr = cs % 100;
        return {seg(mi / 10), seg(mi % 10), seg(se / 10), seg(se % 10), seg(fr / 10), seg(fr % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mt_w[i] = m_init[i]; mt_b[i] = m_init[i]; m_st[i] = S_IDLE; m_ph[i] = 0;
            m_psd[i] = 0; m_win[i] = 0; m_we[i] = 0; m_stm[i] = 0;
        end
    endtask

    task automatic model_step(input logic s, input logic md, input logic p, input logic ng);
        for (int i = 0; i < 3; i++) begin
            int side;
            bit tk, to;
            to = 0;
            if (ng) begin
                mt_w[i] = m_init[i]; mt_b[i] = m_init[i]; m_st[i] = S_IDLE; m_ph[i] = 0;
                m_win[i] = 0; m_we[i] = 0;
            end else begin
                case (m_st[i])
                    S_IDLE: if (s) m_st[i] = S_RW;
                    S_RW, S_RB: begin
                        side = (m_st[i] == S_RB) ? 1 : 0;
                        tk = (m_ph[i] == m_div[i] - 1);
                        m_ph[i] = tk ? 0 : m_ph[i] + 1;
                        if (tk && side == 0 && mt_w[i] > 0) begin mt_w[i]--; to = (mt_w[i] == 0); end
                        if (tk && side == 1 && mt_b[i] > 0) begin mt_b[i]--; to = (mt_b[i] == 0); end
                        if (to) begin
                            m_st[i] = S_DONE; m_win[i] = (side == 0); m_we[i] = 1;
                        end else if (p) begin
                            m_st[i] = S_PAUSED; m_psd[i] = (side == 1); m_ph[i] = 0;
                        end else if (md) begin
                            m_st[i] = (side == 1) ? S_RW : S_RB; m_ph[i] = 0;
                        end
                    end
                    S_PAUSED: if (p) m_st[i] = m_psd[i] ? S_RB : S_RW;
                    default: ;
                endcase
            end
            case (m_st[i])
                S_IDLE, S_RW: m_stm[i] = 0;
                S_RB:         m_stm[i] = 1;
                S_PAUSED:     m_stm[i] = m_psd[i];
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic s, input logic md, input logic p, input logic ng);
        @(negedge clock);
        start = s; move_done = md; pause = p; new_game = ng;
        @(posedge clock);
        model_step(s, md, p, ng);
        #1;
        start = 0; move_done = 0; pause = 0; new_game = 0;
    endtask

    task automatic test_reset();
        logic [41:0] ten_min;
        ten_min = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        reset = 1; start = 0; move_done = 0; pause = 0; new_game = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks += 4;
            if (wclk[i] !== disp(m_init[i])) begin n_fail++; $display("FAIL reset_white[%0d] got %h want %h", i, wclk[i], disp(m_init[i])); end
            if (bclk[i] !== disp(m_init[i])) begin n_fail++; $display("FAIL reset_black[%0d] got %h want %h", i, bclk[i], disp(m_init[i])); end
            if (we[i] !== 1'b0 || win[i] !== 1'b0) begin n_fail++; $display("FAIL reset_winner[%0d] got we=%b win=%b want 0 0", i, we[i], win[i]); end
            if (stm[i] !== 1'b0) begin n_fail++; $display("FAIL reset_side[%0d] got %b want 0", i, stm[i]); end
        end
        n_checks++;
        if (wclk[2] !== ten_min) begin n_fail++; $display("FAIL reset_10min got %h want %h", wclk[2], ten_min); end
        @(negedge clock);
        reset = 0;
        cycle(0, 0, 0, 0);
        n_checks++;
        if (wclk[0] !== disp(300)) begin n_fail++; $display("FAIL reset_release got %h want %h", wclk[0], disp(300)); end
    endtask

    task automatic test_run_white();
        logic [41:0] d150;
        d150 = {7'h40, 7'h40, 7'h40, 7'h79, 7'h12, 7'h40};
        cycle(1, 0, 0, 0);
        repeat (150) cycle(0, 0, 0, 0);
        n_checks += 5;
        if (wclk[0] !== d150) begin n_fail++; $display("FAIL run_white got %h want %h", wclk[0], d150); end
        if (bclk[0] !== disp(300)) begin n_fail++; $display("FAIL run_black_idle got %h want %h", bclk[0], disp(300)); end
        if (wclk[2] !== disp(mt_w[2])) begin n_fail++; $display("FAIL run_prescaled got %h want %h", wclk[2], disp(mt_w[2])); end
        if (we[1] !== 1'b1 || win[1] !== 1'b1) begin n_fail++; $display("FAIL run_short_timeout got we=%b win=%b want 1 1", we[1], win[1]); end
        if (stm[0] !== 1'b0) begin n_fail++; $display("FAIL run_side got %b want 0", stm[0]); end
    endtask

    task automatic test_move_done();
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        repeat (9) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        n_checks += 5;
        if (wclk[0] !== disp(290)) begin n_fail++; $display("FAIL move_white got %h want %h", wclk[0], disp(290)); end
        if (bclk[0] !== disp(295)) begin n_fail++; $display("FAIL move_black got %h want %h", bclk[0], disp(295)); end
        if (stm[0] !== 1'b1) begin n_fail++; $display("FAIL move_side got %b want 1", stm[0]); end
        if (wclk[2] !== disp(mt_w[2])) begin n_fail++; $display("FAIL move_presc_w got %h want %h", wclk[2], disp(mt_w[2])); end
        if (bclk[2] !== disp(mt_b[2])) begin n_fail++; $display("FAIL move_presc_b got %h want %h", bclk[2], disp(mt_b[2])); end
    endtask

    task automatic test_pause();
        logic [41:0] hw, hb;
        cycle(0, 0, 1, 0);
        hw = disp(mt_w[0]);
        hb = disp(mt_b[0]);
        repeat (50) cycle(0, 1, 0, 0);
        n_checks += 3;
        if (wclk[0] !== hw) begin n_fail++; $display("FAIL pause_hold_w got %h want %h", wclk[0], hw); end
        if (bclk[0] !== hb) begin n_fail++; $display("FAIL pause_hold_b got %h want %h", bclk[0], hb); end
        if (stm[0] !== 1'b1) begin n_fail++; $display("FAIL pause_side got %b want 1", stm[0]); end
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        n_checks += 2;
        if (bclk[0] !== disp(mt_b[0])) begin n_fail++; $display("FAIL resume_black got %h want %h", bclk[0], disp(mt_b[0])); end
        if (wclk[0] !== hw) begin n_fail++; $display("FAIL resume_white got %h want %h", wclk[0], hw); end
        cycle(0, 1, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        n_checks += 2;
        if (stm[0] !== 1'b1) begin n_fail++; $display("FAIL pause_over_move got %b want 1", stm[0]); end
        if (bclk[0] !== disp(mt_b[0])) begin n_fail++; $display("FAIL pause_over_move_b got %h want %h", bclk[0], disp(mt_b[0])); end
    endtask

    task automatic test_timeout();
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        n_checks += 4;
        if (we[1] !== 1'b1) begin n_fail++; $display("FAIL timeout_we got %b want 1", we[1]); end
        if (win[1] !== 1'b1) begin n_fail++; $display("FAIL timeout_winner got %b want 1", win[1]); end
        if (wclk[1] !== disp(0)) begin n_fail++; $display("FAIL timeout_zero got %h want %h", wclk[1], disp(0)); end
        if (stm[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_side got %b want 0", stm[1]); end
        cycle(1, 1, 1, 0);
        cycle(0, 0, 0, 0);
        n_checks += 2;
        if (we[1] !== 1'b1 || win[1] !== 1'b1) begin n_fail++; $display("FAIL done_hold got we=%b win=%b want 1 1", we[1], win[1]); end
        if (bclk[1] !== disp(2)) begin n_fail++; $display("FAIL done_hold_b got %h want %h", bclk[1], disp(2)); end
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        n_checks += 3;
        if (we[1] !== 1'b1 || win[1] !== 1'b0) begin n_fail++; $display("FAIL black_timeout got we=%b win=%b want 1 0", we[1], win[1]); end
        if (stm[1] !== 1'b1) begin n_fail++; $display("FAIL black_timeout_side got %b want 1", stm[1]); end
        if (wclk[1] !== disp(1)) begin n_fail++; $display("FAIL black_timeout_w got %h want %h", wclk[1], disp(1)); end
    endtask

    task automatic test_random();
        logic s, md, p, ng;
        cycle(0, 0, 0, 1);
        for (int c = 0; c < 2500; c++) begin
            s  = ($urandom % 8) == 0;
            md = ($urandom % 6) == 0;
            p  = ($urandom % 12) == 0;
            ng = ($urandom % 200) == 0;
            cycle(s, md, p, ng);
            for (int i = 0; i < 3; i++) begin
                n_checks += 5;
                if (wclk[i] !== disp(mt_w[i])) begin n_fail++; $display("FAIL rand_white[%0d] c=%0d got %h want %h", i, c, wclk[i], disp(mt_w[i])); end
                if (bclk[i] !== disp(mt_b[i])) begin n_fail++; $display("FAIL rand_black[%0d] c=%0d got %h want %h", i, c, bclk[i], disp(mt_b[i])); end
                if (win[i] !== m_win[i]) begin n_fail++; $display("FAIL rand_winner[%0d] c=%0d got %b want %b", i, c, win[i], m_win[i]); end
                if (we[i] !== m_we[i]) begin n_fail++; $display("FAIL rand_we[%0d] c=%0d got %b want %b", i, c, we[i], m_we[i]); end
                if (stm[i] !== m_stm[i]) begin n_fail++; $display("FAIL rand_side[%0d] c=%0d got %b want %b", i, c, stm[i], m_stm[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [41:0] ten_min;
        ten_min = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        repeat (9) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        guard = 0;
        while (mt_b[0] != 123 && guard < 400) begin
            cycle(0, 0, 0, 0);
            guard++;
        end
        n_checks++;
        if (bclk[0] !== disp(123)) begin n_fail++; $display("FAIL mid_reach_123 got %h want %h", bclk[0], disp(123)); end
        @(negedge clock);
        #2 reset = 1;
        model_reset();
        #1;
        n_checks += 4;
        if (bclk[0] !== disp(300)) begin n_fail++; $display("FAIL mid_reset_b got %h want %h", bclk[0], disp(300)); end
        if (wclk[0] !== disp(300)) begin n_fail++; $display("FAIL mid_reset_w got %h want %h", wclk[0], disp(300)); end
        if (stm[0] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_side got %b want 0", stm[0]); end
        if (wclk[2] !== ten_min) begin n_fail++; $display("FAIL mid_reset_10min got %h want %h", wclk[2], ten_min); end
        @(negedge clock);
        reset = 0;
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        n_checks++;
        if (we[1] !== 1'b1) begin n_fail++; $display("FAIL mid_done got %b want 1", we[1]); end
        cycle(0, 0, 0, 1);
        n_checks += 4;
        if (we[1] !== 1'b0 || win[1] !== 1'b0) begin n_fail++; $display("FAIL newgame_clear got we=%b win=%b want 0 0", we[1], win[1]); end
        if (wclk[1] !== disp(2)) begin n_fail++; $display("FAIL newgame_reload got %h want %h", wclk[1], disp(2)); end
        if (wclk[2] !== ten_min) begin n_fail++; $display("FAIL newgame_10min_w got %h want %h", wclk[2], ten_min); end
        if (bclk[2] !== ten_min) begin n_fail++; $display("FAIL newgame_10min_b got %h want %h", bclk[2], ten_min); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_run_white();
        test_move_done();
        test_pause();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chess_clock_timer.md
CHESS_CLOCK_TIMER -- requirements
Module: chess_clock_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter INIT_CS, default 60000, meaning initial time per side in centiseconds (10:00.00); legal range 1..599999.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins the game.
REQ-006 The block SHALL have port move_done, input, 1 bit: single-cycle pulse that ends the running side's move (from keyboard_input on a committed move).
REQ-007 The block SHALL have port pause, input, 1 bit: single-cycle pulse that toggles pause.
REQ-008 The block SHALL have port new_game, input, 1 bit: single-cycle pulse that reloads both sides and returns to IDLE.
REQ-009 The block SHALL have port white_clock, output, 42 bits: white time display for vga_controller.
REQ-010 The block SHALL have port black_clock, output, 42 bits: black time display for vga_controller.
REQ-011 The block SHALL have port winner, output, 1 bit: 0 = white won, 1 = black won.
REQ-012 The block SHALL have port winnerEnable, output, 1 bit: high when the game has ended on time.
REQ-013 The block SHALL have port side_to_move, output, 1 bit: 0 = white, 1 = black.

Function
REQ-014 The block SHALL keep one centisecond counter per side, each 20 bits, unsigned, loaded with INIT_CS.
REQ-015 The block SHALL run a prescaler that counts 0..CLK_HZ/100-1 and produces a one-cycle tick on wrap; the prescaler SHALL count only in RUN_W/RUN_B and SHALL clear on every side switch, pause entry and new_game.
REQ-016 The FSM SHALL have states IDLE, RUN_W, RUN_B, PAUSED, DONE.
REQ-017 IDLE + start SHALL go to RUN_W; all other inputs SHALL be ignored in IDLE except new_game.
REQ-018 RUN_W + move_done SHALL go to RUN_B; RUN_B + move_done SHALL go to RUN_W.
REQ-019 RUN_W/RUN_B + pause SHALL go to PAUSED and remember the running side; PAUSED + pause SHALL return to that side; move_done and start SHALL be ignored in PAUSED.
REQ-020 On a tick in RUN_W, the block SHALL decrement only the white counter; on a tick in RUN_B, it SHALL decrement only the black counter.
REQ-021 A decrement from 1 to 0 SHALL move the FSM to DONE on the next edge, with winner = opposite of the running side and winnerEnable = 1; a counter SHALL never wrap below 0.
REQ-022 DONE SHALL hold all values; only new_game or reset SHALL leave it.
REQ-023 If a tick-to-zero and move_done occur in the same cycle, timeout SHALL win (DONE); if a tick-to-zero and pause occur in the same cycle, timeout SHALL win.
REQ-024 If a move_done and pause occur in the same cycle, pause SHALL take priority and the side SHALL NOT switch.
REQ-025 new_game in any state SHALL reload both counters to INIT_CS, clear winnerEnable and winner, and go to IDLE; new_game SHALL have priority over every other input.
REQ-026 side_to_move SHALL be 1 in RUN_B and in PAUSED-from-black; it SHALL hold its last value in DONE and be 0 in IDLE.
REQ-027 Display encoding: each 42-bit output SHALL be six 7-bit active-low seven-segment fields (bit0 = segment a … bit6 = g, same map as Hexadecimal_To_Seven_Segment); [41:35] = tens of minutes, [34:28] = minutes, [27:21] = tens of seconds, [20:14] = seconds, [13:7] = tenths, [6:0] = hundredths.
REQ-028 The block SHALL perform the binary-to-digit conversion with registered per-digit BCD down-counters kept in lockstep with the binary counter (no combinational divider); digits SHALL borrow correctly at x:x0.00 and at seconds 00 → 59.
REQ-029 The display outputs SHALL be registered and SHALL reflect a counter update at most 1 cycle after the decrement.

Reset
REQ-030 While reset is high, the block SHALL set the FSM to IDLE, both counters to INIT_CS, the prescaler to 0, winner = 0, winnerEnable = 0, side_to_move = 0, and both displays to the encoding of INIT_CS (default "10:00.00").
REQ-031 Reset SHALL take effect immediately (asynchronously) and SHALL be released synchronously on the first rising clock after deassertion, with no tick in that cycle.

Verification
REQ-032 With CLK_HZ = 100 and INIT_CS = 300, pulse start and wait 150 cycles: the white counter SHALL be 150, black SHALL be 300, and white_clock SHALL encode 00:01.50.
REQ-033 With the same configuration, pulse move_done after 10 ticks and then wait 5 ticks: white SHALL be 290, black SHALL be 295, and side_to_move SHALL be 1.
REQ-034 Pulse pause in RUN_B, wait 50 cycles, then pulse pause: no counter SHALL change while paused, and the FSM SHALL return to RUN_B.
REQ-035 With INIT_CS = 2, start and run 2 ticks: the FSM SHALL reach DONE, winner SHALL be 1, and winnerEnable SHALL be 1; a move_done pulse on the zero tick SHALL still yield DONE.
REQ-036 Assert reset mid-RUN_B at counter 123: outputs SHALL return to their REQ-030 values within the same cycle; a subsequent new_game while in DONE SHALL clear winnerEnable and reload "10:00.00".
